// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
// Optional even parity is selected with FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int WORD_BITS         = 16;
    localparam int FRAME_BITS_PLAIN  = 10;
    localparam int FRAME_BITS_PARITY = 11;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] i_byte);
        return ^i_byte;
    endfunction
`else
    localparam int FRAME_BITS = FRAME_BITS_PLAIN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-time down-counter with restart, one-cycle tick at expiry
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_restart) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // Counter rests at zero while idle, so the tick is qualified by enable.
    assign o_tick = i_enable && (r_cnt == 16'd0);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops 16-bit words from a show-ahead FIFO and sends them as two UART frames
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit to every frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_BITS-1:0] fifo_rdata,
    input  logic                 fifo_empty,
    output logic                 fifo_ren,
    output logic                 tx,
    output logic                 busy
);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_next;
    logic                   r_hi_byte;
    logic                   w_hi_next;
    logic [WORD_BITS-1:0]   r_word;
    logic [WORD_BITS-1:0]   w_word_next;
    logic [DATA_BITS-1:0]   w_byte_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   w_ren;
    logic                   w_restart;
    logic                   w_tick;
    logic                   w_busy;

    assign w_busy = (r_state != ST_IDLE);

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (w_busy),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_hi_next    = r_hi_byte;
        w_ren        = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so no pop can be requested while reset is held.
                if (!fifo_empty && rst_n) begin
                    w_ren        = 1'b1;
                    w_restart    = 1'b1;
                    w_hi_next    = 1'b0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_restart    = 1'b1;
                    w_idx_next   = 3'd0;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_restart = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_idx_next = 3'(r_idx + 3'd1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_restart    = 1'b1;
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (!r_hi_byte) begin
                        w_restart    = 1'b1;
                        w_hi_next    = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_word_next = w_ren ? fifo_rdata : r_word;
    assign w_byte_next = w_hi_next ? w_word_next[15:8] : w_word_next[7:0];

    // tx is registered from the state being entered, so it lines up with that bit.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_IDLE:   w_tx_next = 1'b1;
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_byte_next[w_idx_next];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = even_parity(w_byte_next);
`endif
            ST_STOP:   w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 3'd0;
            r_hi_byte <= 1'b0;
            r_word    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_hi_byte <= w_hi_next;
            r_word    <= w_word_next;
            r_tx      <= w_tx_next;
        end
    end

    assign fifo_ren = w_ren;
    assign tx       = r_tx;
    assign busy     = w_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int CPB   = 2;
    localparam int FRAME = 11;
`else
    localparam int CPB   = 4;
    localparam int FRAME = 10;
`endif
    localparam int WORD_CYCLES = 2 * FRAME * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fifo_rdata = 16'h0000;
    logic        fifo_empty = 1'b1;
    logic        fifo_ren;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Frames are stored with bit 0 = first bit on the line (start bit).
    typedef struct {
        logic [15:0] word;
        logic [10:0] lo;
        logic [10:0] hi;
        bit          scramble;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic [10:0] lo,
                             input logic [10:0] hi, input bit scr);
        int          busy_cnt;
        logic [10:0] fr;
        int          f;
        int          b;
        busy_cnt = 0;
        @(negedge clk);
        fifo_rdata = w;
        fifo_empty = 1'b0;
        #1;
        check("pop_ren", fifo_ren, 1);
        check("pop_busy", busy, 0);
        for (int k = 0; k < WORD_CYCLES; k++) begin
            @(negedge clk);
            if (scr && k != WORD_CYCLES - 1) begin
                fifo_rdata = 16'($urandom);
                fifo_empty = 1'($urandom);
            end else begin
                fifo_empty = 1'b1;
            end
            #1;
            f  = k / (FRAME * CPB);
            b  = (k / CPB) % FRAME;
            fr = (f != 0) ? hi : lo;
            check("tx_bit", tx, fr[b]);
            check("ren_inflight", fifo_ren, 0);
            if (busy) busy_cnt++;
        end
        @(negedge clk);
        #1;
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);
        check("idle_ren", fifo_ren, 0);
        check("busy_cycles", busy_cnt, WORD_CYCLES);
    endtask

    initial begin
`ifdef FIFO_UART_TX_PARITY_EN
        vecs[0] = '{16'hA55A, 11'h4B4, 11'h54A, 1'b0};
        vecs[1] = '{16'h0001, 11'h602, 11'h400, 1'b0};
        vecs[2] = '{16'hFFFF, 11'h5FE, 11'h5FE, 1'b0};
        vecs[3] = '{16'h0703, 11'h406, 11'h60E, 1'b0};
        vecs[4] = '{16'hBEEF, 11'h7DE, 11'h57C, 1'b1};
        vecs[5] = '{16'h1234, 11'h668, 11'h424, 1'b1};
`else
        vecs[0] = '{16'hA55A, 11'h2B4, 11'h34A, 1'b0};
        vecs[1] = '{16'h0001, 11'h202, 11'h200, 1'b0};
        vecs[2] = '{16'hFFFF, 11'h3FE, 11'h3FE, 1'b0};
        vecs[3] = '{16'h0703, 11'h206, 11'h20E, 1'b0};
        vecs[4] = '{16'hBEEF, 11'h3DE, 11'h37C, 1'b1};
        vecs[5] = '{16'h1234, 11'h268, 11'h224, 1'b1};
`endif

        // Reset with a non-empty FIFO: no pop may be requested.
        fifo_empty = 1'b0;
        fifo_rdata = 16'hA55A;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ren", fifo_ren, 0);
        fifo_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            check("empty_ren", fifo_ren, 0);
            check("empty_tx", tx, 1);
            check("empty_busy", busy, 0);
        end

        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].word, vecs[v].lo, vecs[v].hi, vecs[v].scramble);
        end

        // Back-to-back words: second pop follows the single idle cycle.
        begin
            int gap;
            gap = 0;
            @(negedge clk);
            fifo_rdata = 16'h0001;
            fifo_empty = 1'b0;
            #1;
            check("b2b_first_ren", fifo_ren, 1);
            for (int i = 1; i <= 300; i++) begin
                @(negedge clk);
                fifo_rdata = 16'hFFFF;
                #1;
                if (fifo_ren) begin
                    gap = i;
                    break;
                end
            end
            check("b2b_gap", gap, WORD_CYCLES + 1);
            check("b2b_idle_tx", tx, 1);
            check("b2b_idle_busy", busy, 0);
            @(negedge clk);
            fifo_empty = 1'b1;
            gap = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                #1;
                if (!busy) begin
                    gap = 1;
                    break;
                end
            end
            check("b2b_drain", gap, 1);
        end

        // Reset during data bit 3 of 0x1234 (low byte 0x34, bit 3 = 0).
        @(negedge clk);
        fifo_rdata = 16'h1234;
        fifo_empty = 1'b0;
        #1;
        check("mid_pop_ren", fifo_ren, 1);
        @(negedge clk);
        fifo_empty = 1'b1;
        repeat (4 * CPB + 1) @(negedge clk);
        #1;
        check("mid_pre_tx", tx, 0);
        check("mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ren", fifo_ren, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_tx", tx, 1);
            check("post_rst_busy", busy, 0);
            check("post_rst_ren", fifo_ren, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
